// File: rtl/sub_sklansky_pipe.sv
// Two-stage pipelined subtractor: d = a - b - bin computed as a + ~b + ~bin
// on a Sklansky prefix network, with valid/ready flow control on both sides.
module sub_sklansky_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned LEVELS    = $clog2(WIDTH);
    localparam int unsigned S1_LEVELS = (LEVELS + 1) / 2;

    logic             cin;
    logic [WIDTH-1:0] g0, p0, g1, p1;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_g, s1_p, s1_pb;
    logic             s1_cin, s1_amsb, s1_bmsb;
    logic [WIDTH-1:0] g2, p2, carry, sum;
    logic             adv2;

    assign adv2     = ~out_valid | out_ready;
    assign in_ready = reset_n & (~s1_valid | adv2);

    // Carry-in folds into bit 0's generate, so group G[i] is the carry out of bit i.
    always_comb begin
        cin   = ~bin;
        p0    = a ^ ~b;
        g0    = a & ~b;
        g0[0] = g0[0] | (p0[0] & cin);
        g1    = g0;
        p1    = p0;
        for (int unsigned k = 0; k < S1_LEVELS; k++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i >> k) & 1) != 0) begin
                    g1[i] = g1[i] | (p1[i] & g1[((i >> k) << k) - 1]);
                    p1[i] = p1[i] & p1[((i >> k) << k) - 1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_pb    <= '0;
            s1_cin   <= 1'b0;
            s1_amsb  <= 1'b0;
            s1_bmsb  <= 1'b0;
        end else if (~s1_valid | adv2) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_g    <= g1;
                s1_p    <= p1;
                s1_pb   <= p0;
                s1_cin  <= cin;
                s1_amsb <= a[WIDTH-1];
                s1_bmsb <= b[WIDTH-1];
            end
        end
    end

    always_comb begin
        g2 = s1_g;
        p2 = s1_p;
        for (int unsigned k = S1_LEVELS; k < LEVELS; k++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i >> k) & 1) != 0) begin
                    g2[i] = g2[i] | (p2[i] & g2[((i >> k) << k) - 1]);
                    p2[i] = p2[i] & p2[((i >> k) << k) - 1];
                end
            end
        end
        carry = {g2[WIDTH-2:0], s1_cin};
        sum   = s1_pb ^ carry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                d    <= sum;
                bout <= ~g2[WIDTH-1];
                ovf  <= (s1_amsb != s1_bmsb) && (sum[WIDTH-1] != s1_amsb);
                zero <= ~|sum;
            end
        end
    end

endmodule

// File: tb/tb_sub_sklansky_pipe.sv
// Bench for sub_sklansky_pipe: directed cases on WIDTH=16 plus randomized traffic
// on WIDTH 2/7/16/64 instances checked against an arithmetic reference model.
module tb_sub_sklansky_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        bin = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        ir2, ir7, ir16, ir64;
    logic        ov2, ov7, ov16, ov64;
    logic [1:0]  d2;
    logic [6:0]  d7;
    logic [15:0] d16;
    logic [63:0] d64;
    logic        bo2, bo7, bo16, bo64;
    logic        of2, of7, of16, of64;
    logic        z2, z7, z16, z64;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
    } xfer_t;

    typedef struct packed {
        logic [63:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    xfer_t q[$];

    always #5 clk = ~clk;

    sub_sklansky_pipe #(.WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a[1:0]), .b(b[1:0]), .bin(bin), .out_valid(ov2), .out_ready(out_ready),
        .d(d2), .bout(bo2), .ovf(of2), .zero(z2));

    sub_sklansky_pipe #(.WIDTH(7)) dut7 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir7),
        .a(a[6:0]), .b(b[6:0]), .bin(bin), .out_valid(ov7), .out_ready(out_ready),
        .d(d7), .bout(bo7), .ovf(of7), .zero(z7));

    sub_sklansky_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir16),
        .a(a[15:0]), .b(b[15:0]), .bin(bin), .out_valid(ov16), .out_ready(out_ready),
        .d(d16), .bout(bo16), .ovf(of16), .zero(z16));

    sub_sklansky_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir64),
        .a(a), .b(b), .bin(bin), .out_valid(ov64), .out_ready(out_ready),
        .d(d64), .bout(bo64), .ovf(of64), .zero(z64));

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // True-range arithmetic: borrow and overflow come from unbounded integer results.
    function automatic res_t ref_sub(input int unsigned w, input logic [63:0] x,
                                     input logic [63:0] y, input logic bi);
        logic [64:0]        m65;
        logic [63:0]        mask;
        logic signed [67:0] ux, uy, sx, sy, r, lim, bx;
        res_t               res;
        m65  = (65'd1 << w) - 65'd1;
        mask = m65[63:0];
        ux   = $signed({4'b0, x & mask});
        uy   = $signed({4'b0, y & mask});
        bx   = $signed({67'b0, bi});
        r    = ux - uy - bx;
        res.bout = (r < 0);
        res.d    = r[63:0] & mask;
        res.zero = (res.d == 64'd0);
        lim  = 68'sd1 <<< (w - 1);
        sx   = x[w-1] ? ux - (lim <<< 1) : ux;
        sy   = y[w-1] ? uy - (lim <<< 1) : uy;
        r    = sx - sy - bx;
        res.ovf = (r >= lim) || (r < -lim);
        return res;
    endfunction

    function automatic logic [71:0] pk(input logic [63:0] dv, input logic bo,
                                       input logic of, input logic z);
        return {5'b0, of, z, bo, dv};
    endfunction

    task automatic check_all(input string tag, input xfer_t x);
        res_t e;
        e = ref_sub(2, x.a, x.b, x.bin);
        check({tag, "_w2"}, pk(64'(d2), bo2, of2, z2), pk(e.d, e.bout, e.ovf, e.zero));
        e = ref_sub(7, x.a, x.b, x.bin);
        check({tag, "_w7"}, pk(64'(d7), bo7, of7, z7), pk(e.d, e.bout, e.ovf, e.zero));
        e = ref_sub(16, x.a, x.b, x.bin);
        check({tag, "_w16"}, pk(64'(d16), bo16, of16, z16), pk(e.d, e.bout, e.ovf, e.zero));
        e = ref_sub(64, x.a, x.b, x.bin);
        check({tag, "_w64"}, pk(d64, bo64, of64, z64), pk(e.d, e.bout, e.ovf, e.zero));
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic bi);
        in_valid = v;
        a = {48'b0, x};
        b = {48'b0, y};
        bin = bi;
    endtask

    // One isolated WIDTH=16 transfer: accepted at the first edge, visible after the second.
    task automatic xfer16(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic bi, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
        @(negedge clk);
        drive(1'b1, x, y, bi);
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 72'(ir16), 72'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1_valid"}, 72'(ov16), 72'(0));
        @(negedge clk);
        #1;
        check({tag, "_lat2_valid"}, 72'(ov16), 72'(1));
        check({tag, "_result"}, pk(64'(d16), bo16, of16, z16), pk(64'(ed), eb, eo, ez));
    endtask

    initial begin
        logic        hold_pending;
        logic [71:0] hold_val;
        int          issued;
        xfer_t       x;

        #1 reset_n = 1'b0;
        #2;
        check("rst_in_ready", 72'({ir2, ir7, ir16, ir64}), 72'(0));
        check("rst_out_valid", 72'({ov2, ov7, ov16, ov64}), 72'(0));
        check("rst_out16", pk(64'(d16), bo16, of16, z16), pk(64'd0, 1'b0, 1'b0, 1'b0));
        check("rst_out64", pk(d64, bo64, of64, z64), pk(64'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 72'(ir16), 72'(1));

        xfer16("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        xfer16("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        xfer16("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        xfer16("zero_bin", 16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Back-pressure: three transfers offered with out_ready low.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 16'h0100, 16'h0001, 1'b0);
        #1;
        check("bp_ready1", 72'(ir16), 72'(1));
        @(negedge clk);
        drive(1'b1, 16'h0000, 16'h0000, 1'b1);
        #1;
        check("bp_ready2", 72'(ir16), 72'(1));
        @(negedge clk);
        drive(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
        #1;
        check("bp_ready3_full", 72'(ir16), 72'(0));
        check("bp_first", pk(64'(d16), bo16, of16, 1'b0), pk(64'h00FF, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        check("bp_still_full", 72'(ir16), 72'(0));
        check("bp_hold", pk(64'(d16), bo16, of16, ov16), pk(64'h00FF, 1'b0, 1'b0, 1'b1));
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", 72'(ir16), 72'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_second", pk(64'(d16), bo16, of16, ov16), pk(64'hFFFF, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        #1;
        check("bp_third", pk(64'(d16), bo16, of16, ov16), pk(64'h8000, 1'b1, 1'b1, 1'b1));
        @(negedge clk);
        #1;
        check("bp_empty", 72'(ov16), 72'(0));

        // Mid-flight reset with both stages occupied.
        out_ready = 1'b0;
        drive(1'b1, 16'h0010, 16'h0001, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0020, 16'h0002, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_full_valid", 72'(ov16), 72'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 72'({ov2, ov7, ov16, ov64}), 72'(0));
        check("mid_rst_ready", 72'(ir16), 72'(0));
        check("mid_rst_out", pk(64'(d16), bo16, of16, z16), pk(64'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("no_stale", 72'({ov2, ov7, ov16, ov64}), 72'(0));
        end
        xfer16("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        hold_pending = 1'b0;
        hold_val = '0;
        issued = 0;
        for (int cyc = 0; cyc < 40000 && issued < 10000; cyc++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 9) < 7);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            bin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) b = a;
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            check("agree_ready", 72'({ir2, ir7, ir64}), 72'({3{ir16}}));
            check("agree_valid", 72'({ov2, ov7, ov64}), 72'({3{ov16}}));
            if (hold_pending)
                check("hold", pk(64'(d16), bo16, of16, z16) | 72'(ov16) << 68,
                      hold_val | 72'(1) << 68);
            if (ov16 && out_ready) begin
                check("result_expected", 72'(q.size() > 0), 72'(1));
                if (q.size() > 0) begin
                    x = q.pop_front();
                    check_all("rand", x);
                end
            end
            hold_pending = ov16 && !out_ready;
            hold_val = pk(64'(d16), bo16, of16, z16);
            if (in_valid && ir16) begin
                x.a = a;
                x.b = b;
                x.bin = bin;
                q.push_back(x);
                issued++;
            end
        end
        check("issued_all", 72'(issued), 72'(10000));

        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            if (ov16) begin
                x = q.pop_front();
                check_all("drain", x);
            end
            @(negedge clk);
            #1;
        end
        check("drained", 72'(q.size()), 72'(0));
        @(negedge clk);
        #1;
        check("final_idle", 72'(ov16), 72'(0));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
